lfsr_rand_gen: RTL
==================

Name: lfsr_rand_gen

Overview:
- Parametrised pseudo-random draw engine for game logic (power-up drops, spawn choices).
- Free-running Fibonacci LFSR of configurable width and taps, with seed load and zero-lockup protection.
- Each draw mixes the LFSR for a fixed number of cycles, reduces the captured state modulo RANGE with a bit-serial divider, and maps the remainder through a parameter lookup table.
- The result is presented with a valid/ready handshake. Consumers are the game-state FSMs.

Parameters:
- WIDTH, 13, LFSR width in bits (4..32).
- TAPS, 13'h10A9, feedback mask; bit i set means state[i] is XORed into the feedback. Default is bits 12,7,5,3,0.
- SEED, 13'h000F, reset state; also substituted for any zero seed. Must be nonzero.
- SHIFTS, 13, cycles of LFSR advance between draw accept and capture (>=1).
- RANGE, 5, modulus (2..2^OUT_W).
- OUT_W, 4, result width.
- MAP, {4'd5,4'd6,4'd8,4'd4,4'd2}, packed RANGE*OUT_W lookup. Entry r occupies bits [r*OUT_W +: OUT_W].

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- seed_load  in  1  load seed_in into the LFSR this cycle.
- seed_in  in  WIDTH  seed value.
- req  in  1  draw request; accepted only when busy=0.
- busy  out  1  high from accept until the result handshake completes.
- valid  out  1  result available.
- ready  in  1  consumer accepts the result.
- rnd  out  OUT_W  mapped result, stable while valid=1.
- rem  out  $clog2(RANGE)  raw remainder for the current result.
- lfsr_q  out  WIDTH  current LFSR state, for debug.

Behaviour:
- Reset: lfsr_q=SEED; state IDLE; busy=0; valid=0; rnd=0; rem=0; counters=0.
- LFSR:
  - Advances every cycle: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
  - seed_load has priority: lfsr <= (seed_in==0) ? SEED : seed_in.
  - An all-zero state is unreachable.
- FSM states: IDLE, MIX, DIV, OUT.
  - IDLE: req=1 moves to MIX with mix_cnt=0 and busy=1 from the next cycle. req while busy is ignored and not queued.
  - MIX: mix_cnt increments each cycle. When mix_cnt==SHIFTS-1, capture dividend<=lfsr, partial remainder<=0, bit_cnt<=WIDTH-1, then go to DIV.
  - DIV: restoring division, one dividend bit per cycle, MSB first. Each cycle: r' = {r, bit}; if r' >= RANGE then r' -= RANGE. After WIDTH cycles go to OUT.
    - Remainder register width is $clog2(RANGE)+1 bits, so there is no overflow.
  - OUT: on entry, rem<=remainder, rnd<=MAP[remainder], valid=1. Hold until ready=1, then valid=0, busy=0, state IDLE.
- Latency:
  - valid rises exactly SHIFTS+WIDTH+1 cycles after the accept edge.
  - With defaults this is 27 cycles.
  - Minimum turnaround is one idle cycle between draws.
- Outputs rnd and rem keep their last value after the handshake until the next OUT.
- seed_load while busy:
  - Aborts the draw. Next cycle: IDLE, valid=0, busy=0.
  - A req asserted the same cycle as seed_load is dropped.
- reset mid-draw: immediate return to reset values; no partial result is emitted.
- ready while valid=0 has no effect.

Decomposition:
- Shared package rand_pkg holds:
  - the state enum (IDLE/MIX/DIV/OUT);
  - a function lfsr_next(state, taps);
  - localparam REM_W = $clog2(RANGE).
- One natural sub-module, serial_mod: start, dividend, done, remainder. It is WIDTH cycles latency and reusable by other blocks needing small-modulus reduction.
- The LFSR and FSM stay in the top module.

Test Plan:
- Reset then idle 20 cycles -> lfsr_q follows the golden model from 13'h000F. busy=0, valid=0, rnd=0 throughout.
- seed_load with seed_in=0 -> next lfsr_q=13'h000F. With seed_in=13'h1234 -> next lfsr_q=13'h1234.
- WIDTH=4, TAPS=4'hC, SEED=1 -> state sequence has period exactly 15 and never reads 0.
- Single req with ready tied high:
  - valid rises 27 cycles after accept and stays high exactly 1 cycle.
  - rem equals (lfsr at capture) % 5.
  - rnd = {2,4,8,6,5}[rem].
- ready held low 10 cycles after valid -> rnd/rem stable, busy=1, extra req pulses ignored. On ready=1, handshake completes and the next req is accepted.
- seed_load at cycle 5 of MIX and at cycle 3 of DIV -> next cycle IDLE, valid never asserted. A subsequent draw completes normally.
- 10,000 back-to-back draws -> every rnd is in {2,4,5,6,8}, every rem is in 0..4, and all match the reference model.

Source files
------------

// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types and helpers for the LFSR draw engine
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int DEF_RANGE = 5;
    localparam int REM_W     = $clog2(DEF_RANGE);

    // Fibonacci step on a zero-extended state; bits above width are cleared.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] state,
        input logic [31:0] taps,
        input int          width
    );
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return {state[30:0], ^(state & taps)} & mask;
    endfunction

endpackage

// File: rtl/serial_mod.sv
// rtl/serial_mod.sv - bit-serial restoring modulo reduction, WIDTH cycles per operand
module serial_mod #(
    parameter int WIDTH = 13,
    parameter int RANGE = 5,
    localparam int RW   = $clog2(RANGE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             done,
    output logic [RW-1:0]    remainder
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [RW:0] MODULUS = (RW+1)'(RANGE);

    logic [WIDTH-1:0] dvd;
    logic [RW:0]      r;
    logic [RW:0]      r_shift;
    logic [RW:0]      r_next;
    logic [CW-1:0]    bit_cnt;
    logic             running;

    // r stays below RANGE, so the shifted value is below 2*RANGE and one subtract suffices.
    always_comb begin
        r_shift = {r[RW-1:0], dvd[bit_cnt]};
        r_next  = (r_shift >= MODULUS) ? (r_shift - MODULUS) : r_shift;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dvd     <= '0;
            r       <= '0;
            bit_cnt <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dvd     <= dividend;
                r       <= '0;
                bit_cnt <= CW'(WIDTH - 1);
                running <= 1'b1;
            end else if (running) begin
                r <= r_next;
                if (bit_cnt == '0) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt - CW'(1);
                end
            end
        end
    end

    assign remainder = r[RW-1:0];

endmodule

// File: rtl/lfsr_rand_gen.sv
// rtl/lfsr_rand_gen.sv - free-running LFSR with modulo-reduced, table-mapped draws
module lfsr_rand_gen
    import rand_pkg::*;
#(
    parameter int                     WIDTH  = 13,
    parameter logic [WIDTH-1:0]       TAPS   = 13'h10A9,
    parameter logic [WIDTH-1:0]       SEED   = 13'h000F,
    parameter int                     SHIFTS = 13,
    parameter int                     RANGE  = 5,
    parameter int                     OUT_W  = 4,
    parameter logic [RANGE*OUT_W-1:0] MAP    = {4'd5, 4'd6, 4'd8, 4'd4, 4'd2}
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     seed_load,
    input  logic [WIDTH-1:0]         seed_in,
    input  logic                     req,
    output logic                     busy,
    output logic                     valid,
    input  logic                     ready,
    output logic [OUT_W-1:0]         rnd,
    output logic [$clog2(RANGE)-1:0] rem,
    output logic [WIDTH-1:0]         lfsr_q
);

    localparam int RW = $clog2(RANGE);
    localparam int MW = $clog2(SHIFTS + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [MW-1:0]    mix_cnt;
    logic             mod_start;
    logic             mod_done;
    logic [RW-1:0]    mod_rem;
    logic [OUT_W-1:0] map_tab [RANGE];

    for (genvar i = 0; i < RANGE; i++) begin : g_map
        assign map_tab[i] = MAP[i*OUT_W +: OUT_W];
    end

    assign lfsr_nxt = WIDTH'(lfsr_next(32'(lfsr), 32'(TAPS), WIDTH));

    serial_mod #(
        .WIDTH(WIDTH),
        .RANGE(RANGE)
    ) u_mod (
        .clock    (clock),
        .reset    (reset),
        .start    (mod_start),
        .dividend (lfsr),
        .done     (mod_done),
        .remainder(mod_rem)
    );

    // seed_load overrides every transition, which both aborts a draw and drops a same-cycle req.
    always_comb begin
        state_n   = state;
        mod_start = 1'b0;
        if (seed_load) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (req) state_n = MIX;
                MIX: begin
                    if (mix_cnt == MW'(SHIFTS - 1)) begin
                        mod_start = 1'b1;
                        state_n   = DIV;
                    end
                end
                DIV: if (mod_done) state_n = OUT;
                OUT: if (ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr    <= SEED;
            state   <= IDLE;
            mix_cnt <= '0;
            rem     <= '0;
            rnd     <= '0;
        end else begin
            // A zero seed would lock the register, so it is replaced by SEED.
            lfsr    <= seed_load ? ((seed_in == '0) ? SEED : seed_in) : lfsr_nxt;
            state   <= state_n;
            mix_cnt <= (state == MIX) ? (mix_cnt + MW'(1)) : '0;
            if (state == DIV && state_n == OUT) begin
                rem <= mod_rem;
                rnd <= map_tab[mod_rem];
            end
        end
    end

    assign busy   = (state != IDLE);
    assign valid  = (state == OUT);
    assign lfsr_q = lfsr;

endmodule
